// File: rtl/bbmips_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect.
// master = fetch unit, slave = memory/decode/execute environment.
interface bbmips_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_gnt;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_ins_valid;
  logic [DATA_W-1:0] o_ins;
  logic [ADDR_W-1:0] o_ins_pc;
  logic              i_ins_ready;
  logic              i_redir;
  logic [ADDR_W-1:0] i_redir_pc;

  modport master (
    output o_mem_req, o_mem_addr, o_ins_valid, o_ins, o_ins_pc,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ins_ready, i_redir, i_redir_pc
  );

  modport slave (
    input  o_mem_req, o_mem_addr, o_ins_valid, o_ins, o_ins_pc,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ins_ready, i_redir, i_redir_pc
  );
endinterface

// File: rtl/bbmips_fetch.sv
// Decoupled instruction fetch: credit-limited sequential requests to an in-order memory,
// FWFT prefetch FIFO toward decode, redirect flushes buffered and in-flight words.
module bbmips_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           i_clk,
  input logic           i_rst,
  bbmips_fetch_if.master bus
);
  localparam int                INC     = DATA_W / 8;
  localparam int                PW      = $clog2(DEPTH);
  localparam int                CW      = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC_A   = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] PC_MASK = ~(INC_A - ADDR_W'(1));

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ins;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];

  logic          mem_req, ins_valid, issue, resp, keep, pop;
  logic [CW:0]   credit;
  entry_t        head;

  always_comb begin
    // Requests still in flight own a FIFO slot, so the FIFO can never overflow.
    credit    = {1'b0, inflight_q} + {1'b0, count_q};
    mem_req   = (credit < (CW+1)'(DEPTH)) && !bus.i_redir && !i_rst;
    ins_valid = (count_q != '0) && !bus.i_redir;
    issue     = mem_req && bus.i_mem_gnt;
    // A response with nothing outstanding (e.g. a straggler from before reset) is ignored.
    resp      = bus.i_mem_rvalid && (inflight_q != '0);
    keep      = resp && (discard_q == '0) && !bus.i_redir;
    pop       = ins_valid && bus.i_ins_ready;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;

    if (bus.i_redir) begin
      fetch_pc_d = bus.i_redir_pc & PC_MASK;
      resp_pc_d  = bus.i_redir_pc & PC_MASK;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = inflight_q - CW'(resp);
      discard_d  = inflight_q - CW'(resp);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + INC_A;
      if (keep) begin
        fifo_d[wr_ptr_q] = '{pc: resp_pc_q, ins: bus.i_mem_rdata};
        wr_ptr_d         = wr_ptr_q + PW'(1);
        resp_pc_d        = resp_pc_q + INC_A;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
      inflight_d = inflight_q + CW'(issue) - CW'(resp);
      count_d    = count_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

  assign head            = fifo_q[rd_ptr_q];
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_addr  = fetch_pc_q;
  assign bus.o_ins_valid = ins_valid;
  assign bus.o_ins       = head.ins;
  assign bus.o_ins_pc    = head.pc;
endmodule

// File: tb/tb_bbmips_fetch.sv
// Directed bench for bbmips_fetch: an in-order variable-latency memory model (data = address)
// feeds DUT a; DUT b runs free from a wrapping reset PC.
module tb_bbmips_fetch;
  logic clk = 1'b0;
  logic rst, rst_b;
  always #5 clk = ~clk;

  bbmips_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  bbmips_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  bbmips_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.master));
  bbmips_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .bus(bus_b.master));

  typedef struct { logic [31:0] addr; int due; } req_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, lat = 1, dut_out = 0;
  bit stray_ok = 0;
  req_t mq[$];
  logic [31:0] del_pc[$], del_ins[$], iss[$], b_pc[$], b_ins[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] at(input int i);
    return (del_pc.size() > i) ? del_pc[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock: snapshot handshakes before the edge, advance the memory models after it.
  task automatic tick();
    logic iss_a, rv_a, iss_b;
    logic [31:0] aa, ab;
    @(negedge clk);
    iss_a = bus.o_mem_req && bus.i_mem_gnt;
    aa    = bus.o_mem_addr;
    rv_a  = bus.i_mem_rvalid;
    if (bus.o_ins_valid && bus.i_ins_ready) begin
      del_pc.push_back(bus.o_ins_pc);
      del_ins.push_back(bus.o_ins);
    end
    if (iss_a) iss.push_back(aa);
    if (rv_a && !rst && !stray_ok) begin
      assert (dut_out > 0) else $error("rvalid with nothing outstanding");
    end
    iss_b = bus_b.o_mem_req && bus_b.i_mem_gnt;
    ab    = bus_b.o_mem_addr;
    if (bus_b.o_ins_valid && bus_b.i_ins_ready) begin
      b_pc.push_back(bus_b.o_ins_pc);
      b_ins.push_back(bus_b.o_ins);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rv_a && mq.size() > 0) begin
      void'(mq.pop_front());
      if (!rst && dut_out > 0) dut_out--;
    end
    if (iss_a) begin
      mq.push_back('{aa, cyc + lat - 1});
      dut_out++;
    end
    bus.i_mem_rvalid = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.i_mem_rdata  = bus.i_mem_rvalid ? mq[0].addr : 32'h0;
    bus_b.i_mem_rvalid = iss_b && !rst_b;
    bus_b.i_mem_rdata  = ab;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    dut_out = 0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_redir = 1'b0;
    tick();
    tick();
    del_pc.delete();
    del_ins.delete();
    iss.delete();
    rst = 1'b0;
  endtask

  initial begin
    int n0, n1, nlow;
    rst = 1'b1; rst_b = 1'b1;
    bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
    bus.i_ins_ready = 0; bus.i_redir = 0; bus.i_redir_pc = 0;
    bus_b.i_mem_gnt = 1; bus_b.i_mem_rvalid = 0; bus_b.i_mem_rdata = 0;
    bus_b.i_ins_ready = 1; bus_b.i_redir = 0; bus_b.i_redir_pc = 0;
    tick();
    #1;
    chk("rst_req",   32'(bus.o_mem_req), 32'd0);
    chk("rst_addr",  bus.o_mem_addr, 32'h0);
    chk("rst_vld",   32'(bus.o_ins_valid), 32'd0);
    chk("rst_ins",   bus.o_ins, 32'h0);
    chk("rst_pc",    bus.o_ins_pc, 32'h0);
    chk("rst_b_addr", bus_b.o_mem_addr, 32'hFFFF_FFF8);
    chk("rst_b_req", 32'(bus_b.o_mem_req), 32'd0);

    // Streaming, 1-cycle memory, decode always ready
    bus.i_mem_gnt = 1; bus.i_ins_ready = 1; lat = 1;
    rst = 1'b0; rst_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k < 2) chk("t1_startup_vld", 32'(bus.o_ins_valid), 32'd0);
      else begin
        chk("t1_vld", 32'(bus.o_ins_valid), 32'd1);
        chk("t1_pc",  bus.o_ins_pc, 32'(4 * (k - 2)));
        chk("t1_ins", bus.o_ins,    32'(4 * (k - 2)));
      end
      tick();
    end

    // Decode stalled: credits run out at DEPTH
    do_reset();
    bus.i_ins_ready = 0; bus.i_mem_gnt = 1; lat = 1;
    repeat (8) tick();
    #1;
    chk("t2_issued", 32'(iss.size()), 32'd4);
    chk("t2_req",    32'(bus.o_mem_req), 32'd0);
    chk("t2_vld",    32'(bus.o_ins_valid), 32'd1);
    chk("t2_head",   bus.o_ins_pc, 32'h0);
    bus.i_ins_ready = 1;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) chk("t2_order", at(i), 32'(4 * i));
    chk("t2_resume", (iss.size() > 4) ? iss[4] : 32'hDEAD_BEEF, 32'h10);

    // Redirect with three requests outstanding at latency 3
    do_reset();
    lat = 3; bus.i_ins_ready = 1; bus.i_mem_gnt = 1;
    repeat (3) tick();
    #1;
    chk("t3_rvalid", 32'(bus.i_mem_rvalid), 32'd1);
    chk("t3_nodel",  32'(del_pc.size()), 32'd0);
    bus.i_redir = 1; bus.i_redir_pc = 32'h103;
    #1;
    chk("t3_redir_req", 32'(bus.o_mem_req), 32'd0);
    chk("t3_redir_vld", 32'(bus.o_ins_valid), 32'd0);
    tick();
    bus.i_redir = 0;
    n0 = del_pc.size();
    #1;
    chk("t3_addr", bus.o_mem_addr, 32'h100);
    chk("t3_req",  32'(bus.o_mem_req), 32'd1);
    repeat (15) tick();
    chk("t3_first_pc",  at(n0), 32'h100);
    chk("t3_first_ins", (del_ins.size() > n0) ? del_ins[n0] : 32'hDEAD_BEEF, 32'h100);
    nlow = 0;
    for (int i = n0; i < del_pc.size(); i++) if (del_pc[i] < 32'h100) nlow++;
    chk("t3_no_old_pc", 32'(nlow), 32'd0);

    // Redirect coinciding with a response and a pop (count=2, inflight=1)
    do_reset();
    lat = 1; bus.i_mem_gnt = 1; bus.i_ins_ready = 0;
    repeat (3) tick();
    #1;
    chk("t4_head",   bus.o_ins_pc, 32'h0);
    chk("t4_rvalid", 32'(bus.i_mem_rvalid), 32'd1);
    bus.i_ins_ready = 1; bus.i_redir = 1; bus.i_redir_pc = 32'h100;
    #1;
    chk("t4_vld", 32'(bus.o_ins_valid), 32'd0);
    n0 = del_pc.size();
    tick();
    bus.i_redir = 0;
    #1;
    chk("t4_nopop",   32'(del_pc.size()), 32'(n0));
    chk("t4_empty",   32'(bus.o_ins_valid), 32'd0);
    chk("t4_addr",    bus.o_mem_addr, 32'h100);
    chk("t4_req",     32'(bus.o_mem_req), 32'd1);
    repeat (4) tick();
    chk("t4_first_pc", at(n0), 32'h100);

    // Reset mid-stream with two requests outstanding
    do_reset();
    lat = 3; bus.i_mem_gnt = 1; bus.i_ins_ready = 1;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req",  32'(bus.o_mem_req), 32'd0);
    chk("t6_addr", bus.o_mem_addr, 32'h0);
    chk("t6_vld",  32'(bus.o_ins_valid), 32'd0);
    chk("t6_ins",  bus.o_ins, 32'h0);
    chk("t6_pc",   bus.o_ins_pc, 32'h0);
    bus.i_mem_gnt = 0;
    dut_out = 0;
    tick();
    tick();
    rst = 1'b0;
    stray_ok = 1;
    n0 = del_pc.size();
    for (int k = 0; k < 20 && mq.size() > 0; k++) tick();
    chk("t6_drain", 32'(mq.size()), 32'd0);
    chk("t6_stray", 32'(del_pc.size()), 32'(n0));
    chk("t6_stray_vld", 32'(bus.o_ins_valid), 32'd0);
    stray_ok = 0;
    bus.i_mem_gnt = 1;
    n1 = iss.size();
    repeat (8) tick();
    chk("t6_restart_addr", (iss.size() > n1) ? iss[n1] : 32'hDEAD_BEEF, 32'h0);
    chk("t6_first_pc", at(n0), 32'h0);

    // Wrapping reset PC on the second instance
    chk("t5_pc0",  (b_pc.size() > 0) ? b_pc[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("t5_pc1",  (b_pc.size() > 1) ? b_pc[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("t5_pc2",  (b_pc.size() > 2) ? b_pc[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    chk("t5_ins2", (b_ins.size() > 2) ? b_ins[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bbmips_fetch.md
Name: bbmips_fetch

Overview:
Parametrised instruction-fetch unit for the next-generation bbmips core. It replaces the single-cycle PC / PC+4 / ROM path with a decoupled front end. The unit issues sequential fetches to a variable-latency, in-order instruction memory and buffers the returned words with their PCs in a prefetch FIFO. It hands them to decode over a valid/ready handshake and supports a redirect (jump or branch) that flushes the buffered and in-flight fetches.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width; INC = DATA_W/8 bytes per instruction
DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of 2, >= 2
RESET_PC, 0, PC loaded on reset

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
o_mem_req  out  1  fetch request valid
o_mem_addr  out  ADDR_W  fetch address (= fetch_pc)
i_mem_gnt  in  1  memory accepts request this cycle
i_mem_rvalid  in  1  response valid; responses are in request order, latency >= 1 cycle
i_mem_rdata  in  DATA_W  response instruction word
o_ins_valid  out  1  instruction available to decode
o_ins  out  DATA_W  head instruction
o_ins_pc  out  ADDR_W  PC of head instruction
i_ins_ready  in  1  decode consumes head this cycle
i_redir  in  1  redirect request from execute
i_redir_pc  in  ADDR_W  redirect target; low log2(INC) bits forced to 0

Behaviour:
- Reset (async, any time, including mid-burst): fetch_pc=RESET_PC, resp_pc=RESET_PC, count=0, inflight=0, discard=0. All outputs 0 except o_mem_addr=RESET_PC. Memory responses arriving during reset are ignored.
- State: fetch_pc (next address to request); resp_pc (PC tag for the next kept response); FIFO {pc,instr} with count 0..DEPTH; inflight 0..DEPTH; discard 0..inflight.
- Credit rule: o_mem_req = (inflight + count < DEPTH) && !i_redir. This is combinational. The FIFO therefore never overflows; no full flag is needed.
- Issue: on o_mem_req && i_mem_gnt, fetch_pc <= fetch_pc + INC (wraps modulo 2^ADDR_W) and inflight increments.
- o_mem_req and o_mem_addr must stay stable until granted, except that i_redir may withdraw the request.
- Response: each i_mem_rvalid decrements inflight.
  - If discard > 0: decrement discard and drop the word.
  - Otherwise: push {resp_pc, i_mem_rdata} and set resp_pc <= resp_pc + INC (wraps).
  - i_mem_rvalid with inflight=0 is a protocol error; the bench asserts against it.
- Output: first-word-fall-through. o_ins_valid = (count != 0) && !i_redir; o_ins / o_ins_pc show the head entry. A pop occurs on o_ins_valid && i_ins_ready.
- Same-cycle issue, response, push and pop are all legal; counters update by the net amount.
- Redirect (single-cycle pulse, highest priority over everything except reset):
  - FIFO is flushed (count <= 0) and any pop that cycle is ignored.
  - No request is issued that cycle.
  - fetch_pc <= i_redir_pc and resp_pc <= i_redir_pc.
  - discard <= inflight - i_mem_rvalid, so every currently outstanding request is discarded. A response arriving in the redirect cycle is itself dropped.
  - Discarded requests keep consuming credit until their responses return.
- Back-to-back redirects: each one reloads the PCs and recomputes discard; the last one wins.
- Throughput: with 1-cycle memory latency and continuous grant/ready, 1 instruction per cycle after a 2-cycle start-up. First o_ins_valid comes 2 cycles after reset release.

Test Plan:
- Reset release, memory grants always with 1-cycle latency returning data = address, ready=1 -> o_ins_pc/o_ins = 0x0,0x4,0x8,... on consecutive cycles starting at cycle 2.
- i_ins_ready held 0 with DEPTH=4 -> exactly 4 requests issued (addr 0x0..0xC), count=4, o_mem_req=0. Raise ready -> 4 pops in order, then fetching resumes at 0x10.
- Latency 3, three requests outstanding, i_redir with i_redir_pc=0x100 -> the 3 old responses are dropped. The first delivered instruction has o_ins_pc=0x100, and no PC < 0x100 ever appears after the redirect.
- i_redir in the same cycle as i_mem_rvalid and a pop (count=2, inflight=1) -> FIFO empty, discard=0, o_ins_valid=0 that cycle. Next request addr=0x100.
- RESET_PC=0xFFFFFFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 delivered in order.
- Assert i_rst mid-stream with 2 requests outstanding -> all outputs 0 immediately. Late responses after release are ignored, and fetch restarts at RESET_PC.
